// File: rtl/seq_subtractor_nbits_pkg.sv
// Shared types and helpers for the sequential wide subtractor.
//   sub_state_t : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   num_chunks  : ceil(n / chunk), number of CHUNK-wide slices covering an n-bit operand
package seq_subtractor_nbits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int unsigned num_chunks(input int unsigned n, input int unsigned chunk);
    return (n + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/seq_subtractor_nbits_if.sv
// Operand/result bus of the sequential wide subtractor.
//   in_valid/in_ready   : operand handshake (producer -> subtractor)
//   x, y                : minuend, subtrahend (N bits)
//   out_valid/out_ready : result handshake (subtractor -> consumer)
//   diff, borrow_out    : (x - y) mod 2^N, and 1 iff x < y unsigned
//   overflow            : signed overflow, present only when OVERFLOW_DETECT_EN is defined
// Modports: master = producer/consumer side, slave = subtractor side.
interface seq_subtractor_nbits_if #(
  parameter int unsigned N = 34
) ();
  import seq_subtractor_nbits_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow_out;
`ifdef OVERFLOW_DETECT_EN
  logic         overflow;
`endif

  modport master (
    output in_valid, x, y, out_ready,
`ifdef OVERFLOW_DETECT_EN
    input  overflow,
`endif
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, x, y, out_ready,
`ifdef OVERFLOW_DETECT_EN
    output overflow,
`endif
    output in_ready, out_valid, diff, borrow_out
  );

endinterface

// File: rtl/seq_subtractor_nbits_rca.sv
// n-bit ripple-carry adder used for one chunk of the subtractor.
//   i_a, i_b : addends (n bits)
//   i_cin    : carry in
//   o_sum    : i_a + i_b + i_cin, low n bits
//   o_cout   : carry out of the top bit
module seq_subtractor_nbits_rca #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_cin,
  output logic [n-1:0] o_sum,
  output logic         o_cout
);

  always_comb begin
    logic w_c;
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/seq_subtractor_nbits.sv
// Multi-cycle wide subtractor: diff = x - y over N bits, CHUNK bits per cycle,
// computed as x + ~y + 1 with the carry held in a register between chunks.
// One operation in flight; latency from accept edge (counted as edge 1) to
// out_valid high is NUM_CHUNKS+1 edges.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : seq_subtractor_nbits_if.slave (operand/result handshakes, x, y, diff, borrow_out)
// Optional feature: define OVERFLOW_DETECT_EN to add the registered signed-overflow output.
module seq_subtractor_nbits
  import seq_subtractor_nbits_pkg::*;
#(
  parameter int unsigned N     = 34,
  parameter int unsigned CHUNK = 8
) (
  input logic                 clk,
  input logic                 rst,
  seq_subtractor_nbits_if.slave bus
);

  localparam int unsigned NUM_CHUNKS = num_chunks(N, CHUNK);
  localparam int unsigned W          = NUM_CHUNKS * CHUNK;
  localparam int unsigned IDX_W      = $clog2(NUM_CHUNKS) + 1;

  sub_state_t       r_state;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [W-1:0]     r_res;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [N-1:0]     r_diff;
  logic             r_borrow;
`ifdef OVERFLOW_DETECT_EN
  logic             r_x_msb;
  logic             r_y_msb;
  logic             r_overflow;
  logic             w_overflow;
`endif

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [W-1:0]     w_res_next;
  logic             w_last;
  logic             w_borrow;

  // Operands are shifted right one chunk per RUN cycle, so the active chunk is
  // always the low slice; the result fills in from the top and ends aligned.
  seq_subtractor_nbits_rca #(
    .n (CHUNK)
  ) u_rca (
    .i_a    (r_x[CHUNK-1:0]),
    .i_b    (~r_y[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_res_next = (r_res >> CHUNK) | (W'(w_sum) << (W - CHUNK));
  assign w_last     = (r_idx == IDX_W'(NUM_CHUNKS - 1));

  // With padding, the inverted pad bits of y are ones, so bit N of the raw
  // result carries the borrow; without padding the final carry is its inverse.
  if (W > N) begin : g_borrow_pad
    assign w_borrow = w_res_next[N];
  end else begin : g_borrow_exact
    assign w_borrow = ~w_cout;
  end

`ifdef OVERFLOW_DETECT_EN
  assign w_overflow = (r_x_msb != r_y_msb) & (w_res_next[N-1] != r_x_msb);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      r_x_msb     <= 1'b0;
      r_y_msb     <= 1'b0;
      r_overflow  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
          if (bus.in_valid) begin
            r_x        <= W'(bus.x);
            r_y        <= W'(bus.y);
            r_res      <= '0;
            r_carry    <= 1'b1;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
`ifdef OVERFLOW_DETECT_EN
            r_x_msb    <= bus.x[N-1];
            r_y_msb    <= bus.y[N-1];
`endif
          end
        end
        RUN: begin
          r_x     <= r_x >> CHUNK;
          r_y     <= r_y >> CHUNK;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_diff      <= w_res_next[N-1:0];
            r_borrow    <= w_borrow;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef OVERFLOW_DETECT_EN
            r_overflow  <= w_overflow;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow;
`ifdef OVERFLOW_DETECT_EN
  assign bus.overflow   = r_overflow;
`endif

endmodule

// File: tb/tb_seq_subtractor_nbits.sv
// Bench for seq_subtractor_nbits: three instances (CHUNK = 8, 34, 1) at N = 34
// run the same directed vectors side by side; hand-written sequences cover
// back-pressure in DONE and reset during RUN. Overflow checks apply when
// OVERFLOW_DETECT_EN is defined.
module tb_seq_subtractor_nbits;

  localparam int unsigned N = 34;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_subtractor_nbits_if #(.N(N)) bus0 ();
  seq_subtractor_nbits_if #(.N(N)) bus1 ();
  seq_subtractor_nbits_if #(.N(N)) bus2 ();

  seq_subtractor_nbits #(.N(N), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq_subtractor_nbits #(.N(N), .CHUNK(34)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seq_subtractor_nbits #(.N(N), .CHUNK(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0]   ov;
  logic [2:0]   ir;
  logic [2:0]   br;
  logic [2:0]   of;
  logic [N-1:0] df [3];

  assign ov = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign ir = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign br = {bus2.borrow_out, bus1.borrow_out, bus0.borrow_out};
  assign df[0] = bus0.diff;
  assign df[1] = bus1.diff;
  assign df[2] = bus2.diff;
`ifdef OVERFLOW_DETECT_EN
  assign of = {bus2.overflow, bus1.overflow, bus0.overflow};
`else
  assign of = 3'b000;
`endif

  int checks = 0;
  int errors = 0;

  logic [N-1:0] got_diff [3];
  logic         got_br   [3];
  logic         got_ovf  [3];
  int           got_lat  [3];
  bit           got_done [3];
  int           exp_lat  [3];

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_all(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
    bus0.in_valid = v; bus0.x = x; bus0.y = y;
    bus1.in_valid = v; bus1.x = x; bus1.y = y;
    bus2.in_valid = v; bus2.x = x; bus2.y = y;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && ir != 3'b111; c++) @(negedge clk);
    chk("idle_wait", 64'(ir), 64'h7);
  endtask

  // Accept edge counts as edge 1; got_lat is the edge after which out_valid was seen.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      got_done[i] = 1'b0;
      got_lat[i]  = 0;
    end
    @(negedge clk);
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1;
    drive_all(1'b1, x, y);
    @(posedge clk); #1;
    drive_all(1'b0, '0, '0);
    for (int c = 1; c <= 80; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!got_done[i] && ov[i]) begin
          got_done[i] = 1'b1;
          got_lat[i]  = c;
          got_diff[i] = df[i];
          got_br[i]   = br[i];
          got_ovf[i]  = of[i];
        end
      end
      if (got_done[0] && got_done[1] && got_done[2]) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{x: 34'd10,          y: 34'd3,           diff: 34'd7,          borrow: 1'b0, ovf: 1'b0};
    vecs[1] = '{x: 34'd0,           y: 34'd1,           diff: 34'h3_FFFF_FFFF, borrow: 1'b1, ovf: 1'b0};
    vecs[2] = '{x: 34'h3_FFFF_FFFF, y: 34'h3_FFFF_FFFF, diff: 34'd0,          borrow: 1'b0, ovf: 1'b0};
    vecs[3] = '{x: 34'h1_FFFF_FFFF, y: 34'h3_FFFF_FFFF, diff: 34'h2_0000_0000, borrow: 1'b1, ovf: 1'b1};
    vecs[4] = '{x: 34'd100,         y: 34'd58,          diff: 34'd42,         borrow: 1'b0, ovf: 1'b0};
    vecs[5] = '{x: 34'h2_0000_0000, y: 34'd1,           diff: 34'h1_FFFF_FFFF, borrow: 1'b0, ovf: 1'b1};
    vecs[6] = '{x: 34'h1_2345_6789, y: 34'h0_1111_1111, diff: 34'h1_1234_5678, borrow: 1'b0, ovf: 1'b0};
    vecs[7] = '{x: 34'h0_0000_00FF, y: 34'h0_0000_0100, diff: 34'h3_FFFF_FFFF, borrow: 1'b1, ovf: 1'b0};
    vecs[8] = '{x: 34'h0_0000_0100, y: 34'h0_0000_00FF, diff: 34'd1,          borrow: 1'b0, ovf: 1'b0};
    vecs[9] = '{x: 34'h2_0000_0000, y: 34'h2_0000_0000, diff: 34'd0,          borrow: 1'b0, ovf: 1'b0};
    exp_lat[0] = 6;
    exp_lat[1] = 2;
    exp_lat[2] = 35;

    drive_all(1'b0, '0, '0);
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(ir), 64'h7);
    chk("rst_out_valid", 64'(ov), 64'h0);
    chk("rst_borrow", 64'(br), 64'h0);
    chk("rst_overflow", 64'(of), 64'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_diff%0d", i), 64'(df[i]), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on all three chunk widths
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].x, vecs[v].y);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("v%0d_d%0d_done", v, i), 64'(got_done[i]), 64'h1);
        chk($sformatf("v%0d_d%0d_diff", v, i), 64'(got_diff[i]), 64'(vecs[v].diff));
        chk($sformatf("v%0d_d%0d_borrow", v, i), 64'(got_br[i]), 64'(vecs[v].borrow));
        chk($sformatf("v%0d_d%0d_latency", v, i), 64'(got_lat[i]), 64'(exp_lat[i]));
`ifdef OVERFLOW_DETECT_EN
        chk($sformatf("v%0d_d%0d_ovf", v, i), 64'(got_ovf[i]), 64'(vecs[v].ovf));
`endif
      end
    end

    // Back-pressure: result held in DONE, new operands ignored
    wait_idle();
    @(negedge clk);
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1; bus0.x = 34'd12; bus0.y = 34'd5;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    for (int c = 0; c < 20 && !bus0.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("hold_valid_seen", 64'(bus0.out_valid), 64'h1);
    bus0.in_valid = 1'b1; bus0.x = 34'd3; bus0.y = 34'd1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_diff", c), 64'(bus0.diff), 64'd7);
      chk($sformatf("hold%0d_out_valid", c), 64'(bus0.out_valid), 64'h1);
      chk($sformatf("hold%0d_in_ready", c), 64'(bus0.in_ready), 64'h0);
    end
    @(negedge clk);
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 64'(bus0.out_valid), 64'h0);
    chk("release_in_ready", 64'(bus0.in_ready), 64'h1);
    chk("idle_diff_held", 64'(bus0.diff), 64'd7);
    @(posedge clk); #1;
    chk("idle_no_accept", 64'(bus0.in_ready), 64'h1);

    // Reset in the middle of an operation
    wait_idle();
    @(negedge clk);
    drive_all(1'b1, 34'd500, 34'd1);
    @(posedge clk); #1;
    drive_all(1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(ir), 64'h7);
    chk("midrst_out_valid", 64'(ov), 64'h0);
    chk("midrst_borrow", 64'(br), 64'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("midrst_diff%0d", i), 64'(df[i]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(34'd100, 34'd58);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("postrst_d%0d_done", i), 64'(got_done[i]), 64'h1);
      chk($sformatf("postrst_d%0d_diff", i), 64'(got_diff[i]), 64'd42);
      chk($sformatf("postrst_d%0d_latency", i), 64'(got_lat[i]), 64'(exp_lat[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
